// File: rtl/mat_row_seq.sv
// mat_row_seq: streams the rows of a captured N x N matrix, one at a time, to
// a row-wise ALU and reassembles the returned rows into m_out.
// Exactly one row is outstanding at a time, and rows go out in order 0..N-1.
// Optional build macro: MAT_SEQ_TIMEOUT_EN adds a RECV watchdog, a TOUT state
// and a sticky err flag. When the macro is undefined, err is tied low and RECV
// waits for the ALU indefinitely.
module mat_row_seq #(
  parameter int ELEM_W = 8,
  parameter int N      = 5,
  localparam int RW    = N * ELEM_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*RW-1:0] m_in,
  output logic [RW-1:0]   row_out,
  output logic            row_valid,
  input  logic            row_ready,
  input  logic [RW-1:0]   row_in,
  input  logic            row_in_valid,
  output logic [N*RW-1:0] m_out,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_RECV = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
`ifdef MAT_SEQ_TIMEOUT_EN
  localparam logic [2:0] ST_TOUT = 3'd4;
  // The 15th consecutive idle RECV cycle is the one where the counter reads 14.
  localparam logic [3:0] WAIT_LAST = 4'd14;
`endif

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [RW-1:0]    src_rows [N];
  logic [RW-1:0]    res_rows [N];

  logic capture;
  logic row_wr;
  logic last_row;

  // A matrix is taken only from IDLE; start is ignored everywhere else.
  assign capture  = (state_reg == ST_IDLE) && start;
  // Returned rows are accepted only while a row is outstanding.
  assign row_wr   = (state_reg == ST_RECV) && row_in_valid;
  assign last_row = (idx_reg == LAST_IDX);

`ifdef MAT_SEQ_TIMEOUT_EN
  logic [3:0] wait_cnt_reg;
  logic       wait_expired;

  // The valid check comes first, so a row arriving on the final cycle still wins.
  assign wait_expired = (state_reg == ST_RECV) && !row_in_valid &&
                        (wait_cnt_reg == WAIT_LAST);
`endif

  // Next-state decode of the row sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (row_ready) state_next = ST_RECV;
      end
      ST_RECV: begin
        if (row_in_valid) begin
          state_next = last_row ? ST_DONE : ST_SEND;
        end
`ifdef MAT_SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          state_next = ST_TOUT;
        end
`endif
      end
      ST_DONE: state_next = ST_IDLE;
`ifdef MAT_SEQ_TIMEOUT_EN
      ST_TOUT: state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset wins over every other input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Row index: cleared on capture, advanced after each returned row except the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (capture) begin
      idx_reg <= '0;
    end else if (row_wr && !last_row) begin
      idx_reg <= idx_reg + IDX_W'(1);
    end
  end

  // Source matrix snapshot, so later m_in changes cannot disturb a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) src_rows[r] <= '0;
    end else if (capture) begin
      for (int r = 0; r < N; r++) src_rows[r] <= m_in[r*RW +: RW];
    end
  end

  // Result matrix: the returned row lands in the slot of the row that went out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) res_rows[r] <= '0;
    end else if (row_wr) begin
      res_rows[idx_reg] <= row_in;
    end
  end

  // Row presented to the ALU; it stays stable for as long as SEND is held.
  always_comb begin
    row_out = src_rows[idx_reg];
  end

  // Flatten the result rows onto the m_out bus.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mout
      assign m_out[gi*RW +: RW] = res_rows[gi];
    end
  endgenerate

  assign row_valid = (state_reg == ST_SEND);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);

`ifdef MAT_SEQ_TIMEOUT_EN
  // Watchdog: held at zero outside RECV, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg != ST_RECV) begin
      wait_cnt_reg <= '0;
    end else if (!row_in_valid) begin
      wait_cnt_reg <= wait_cnt_reg + 4'd1;
    end
  end

  logic err_reg;

  // Sticky error flag: set on entry to TOUT, cleared by reset or the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (capture) begin
      err_reg <= 1'b0;
    end else if (wait_expired) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mat_row_seq.sv
// tb_mat_row_seq: self-checking bench for mat_row_seq.
// A table of transfer scenarios, a randomized batch and hand-written corner
// sequences drive the bench's own ALU model. Expected results come from
// element-wise negation of the source matrix and from the cycle-count rule
// "done = 11 + ready stalls + withheld return cycles".
module tb_mat_row_seq;

  localparam int ELEM_W = 8;
  localparam int N      = 5;
  localparam int RW     = N * ELEM_W;
  localparam int MW     = N * RW;
`ifdef MAT_SEQ_TIMEOUT_EN
  localparam int LONG_DLY = 14;
  localparam int MAX_DLY  = 14;
`else
  localparam int LONG_DLY = 40;
  localparam int MAX_DLY  = 20;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [MW-1:0] m_in;
  logic [RW-1:0] row_out;
  logic          row_valid;
  logic          row_ready;
  logic [RW-1:0] row_in;
  logic          row_in_valid;
  logic [MW-1:0] m_out;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  mat_row_seq #(.ELEM_W(ELEM_W), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .m_in(m_in),
    .row_out(row_out), .row_valid(row_valid), .row_ready(row_ready),
    .row_in(row_in), .row_in_valid(row_in_valid), .m_out(m_out),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] mat;
    int            stall_row;  // row whose handshake is held off
    int            stall_n;    // cycles row_ready stays low on that row
    int            dly_row;    // row whose result is withheld
    int            dly_n;      // cycles the result is withheld
    bit            inject;     // pulse start and row_in_valid while in SEND
    int            exp_done;   // cycle in which done must be high
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  // ALU reference: two's-complement negation of every element, modulo 2^ELEM_W.
  function automatic logic [RW-1:0] neg_row(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    int v;
    int m;
    m = 1 << ELEM_W;
    for (int e = 0; e < N; e++) begin
      v = int'(r[e*ELEM_W +: ELEM_W]);
      o[e*ELEM_W +: ELEM_W] = ELEM_W'((m - v) % m);
    end
    return o;
  endfunction

  // Runs one transfer. abort_row >= 0 asserts rst in the RECV cycle of that row.
  task automatic run_xfer(input vec_t v, input int abort_row);
    logic [MW-1:0] exp_m;
    logic [RW-1:0] hs_row;
    int row, cyc, ph, stall_left, dly_left, done_at;
    bit injected, seen;
    for (int r = 0; r < N; r++) exp_m[r*RW +: RW] = neg_row(v.mat[r*RW +: RW]);
    hs_row = '0;
    row = 0; cyc = 0; ph = 0; done_at = -1; injected = 0;
    stall_left = v.stall_n; dly_left = v.dly_n;
    m_in = v.mat;
    start = 1'b1;
    while (ph < 3) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; row_in_valid = 1'b0; row_ready = 1'b0;
      case (ph)
        0: begin
          chk("send_row_valid", row_valid, 1);
          chk("send_row_out", row_out, v.mat[row*RW +: RW]);
          chk("send_err_low", err, 0);
          if (row == v.stall_row && stall_left > 0) begin
            stall_left--;
            if (v.inject && !injected) begin
              start = 1'b1; m_in = ~v.mat;
              row_in_valid = 1'b1; row_in = {RW{1'b1}};
              injected = 1;
            end
          end else begin
            row_ready = 1'b1;
            hs_row = row_out;
            ph = 1;
          end
        end
        1: begin
          chk("recv_row_valid", row_valid, 0);
          chk("recv_busy", busy, 1);
          chk("recv_done_low", done, 0);
          chk("recv_err_low", err, 0);
          if (row == abort_row) begin
            rst = 1'b1;
            row_in_valid = 1'b1; row_in = neg_row(hs_row);
            ph = 4;
          end else if (row == v.dly_row && dly_left > 0) begin
            dly_left--;
          end else begin
            row_in_valid = 1'b1; row_in = neg_row(hs_row);
            row++;
            ph = (row == N) ? 2 : 0;
          end
        end
        default: begin
          if (done) begin
            done_at = cyc;
            chk("done_m_out", m_out, exp_m);
            chk("done_busy", busy, 1);
            ph = 3;
          end else if (cyc > v.exp_done + 30) begin
            total++; bad++;
            $display("FAIL done_watchdog actual=no_done_by_cycle_%0d required=%0d", cyc, v.exp_done);
            ph = 3;
          end
        end
      endcase
    end
    if (ph == 4) begin
      @(negedge clk);
      rst = 1'b0; row_in_valid = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_row_valid", row_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_m_out", m_out, '0);
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("abort_no_done", seen, 0);
    end else begin
      chk("done_cycle", done_at, v.exp_done);
      $display("xfer stall=%0d/%0d dly=%0d/%0d inject=%0d done_at=%0d exp=%0d",
               v.stall_row, v.stall_n, v.dly_row, v.dly_n, v.inject, done_at, v.exp_done);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("m_out_hold", m_out, exp_m);
      row_in_valid = 1'b1; row_in = {RW{1'b1}};
      @(negedge clk);
      row_in_valid = 1'b0;
      chk("idle_row_in_ignored", m_out, exp_m);
    end
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; start = 1'b0; m_in = '0; row_ready = 1'b0;
    row_in = '0; row_in_valid = 1'b0;

    tbl[0] = '{mat: {40'h0000000000, 40'h8080808080, 40'h7F7F7F7F7F, 40'h0A0B0C0D0E, 40'h0102030405},
               stall_row: -1, stall_n: 0, dly_row: -1, dly_n: 0, inject: 0, exp_done: 11};
    tbl[1] = tbl[0];
    tbl[1].stall_row = 2; tbl[1].stall_n = 3; tbl[1].exp_done = 14;
    tbl[2] = tbl[0];
    tbl[2].stall_row = 1; tbl[2].stall_n = 2; tbl[2].inject = 1; tbl[2].exp_done = 13;
    tbl[3] = '{mat: {40'h1122334455, 40'hFF01807F00, 40'h0123456789, 40'hDEADBEEF00, 40'h8081828384},
               stall_row: 4, stall_n: 1, dly_row: 0, dly_n: 1, inject: 0, exp_done: 13};
    tbl[4] = tbl[3];
    tbl[4].stall_row = -1; tbl[4].stall_n = 0;
    tbl[4].dly_row = 3; tbl[4].dly_n = LONG_DLY; tbl[4].exp_done = 11 + LONG_DLY;

    // Reset with start and row_in_valid also high: reset must win.
    repeat (2) @(negedge clk);
    start = 1'b1; row_in_valid = 1'b1; m_in = tbl[0].mat;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_row_valid", row_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_m_out", m_out, '0);
    rst = 1'b0; start = 1'b0; row_in_valid = 1'b0;
    @(negedge clk);
    chk("reset_stays_idle", busy, 0);

    for (int i = 0; i < 5; i++) run_xfer(tbl[i], -1);

    // Reset during RECV of row 3, then a fresh transfer.
    run_xfer(tbl[0], 3);
    run_xfer(tbl[0], -1);

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < MW; b += 8) rv.mat[b +: 8] = 8'($urandom);
      rv.stall_row = $urandom_range(0, N - 1);
      rv.stall_n   = $urandom_range(0, 4);
      rv.dly_row   = $urandom_range(0, N - 1);
      rv.dly_n     = $urandom_range(0, MAX_DLY);
      rv.inject    = 0;
      rv.exp_done  = 11 + rv.stall_n + rv.dly_n;
      run_xfer(rv, -1);
    end

`ifdef MAT_SEQ_TIMEOUT_EN
    // No result after the row 0 handshake: 15 RECV cycles, then TOUT.
    m_in = tbl[0].mat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("tout_send", row_valid, 1);
    row_ready = 1'b1;
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      row_ready = 1'b0;
      chk("tout_wait_busy", busy, 1);
      chk("tout_wait_err", err, 0);
    end
    @(negedge clk);
    chk("tout_err_set", err, 1);
    chk("tout_busy", busy, 1);
    chk("tout_done_low", done, 0);
    chk("tout_row_valid", row_valid, 0);
    @(negedge clk);
    chk("tout_busy_drop", busy, 0);
    chk("tout_err_sticky", err, 1);
    chk("tout_done_never", done, 0);
    run_xfer(tbl[0], -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
